// File: rtl/bus_rr_scheduler.sv
// Round-robin packet scheduler: grants one pending source FIFO at a time, pops its head and
// pushes it to the decoded destination(s). Optional macro BUS_SCHED_SELF_SEND_EN allows self-delivery.
module bus_rr_scheduler #(
  parameter int         drvrs     = 8,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic                       busy,
  output logic                       err_dest,
  output logic [$clog2(drvrs)-1:0]   last_src
);
  localparam int LW = $clog2(drvrs);

  typedef enum logic [1:0] {IDLE, GRANT, ROUTE} state_t;

  state_t               state_q, state_d;
  logic [drvrs-1:0]     pop_q, pop_d;
  logic [drvrs-1:0]     push_q, push_d;
  logic [pckg_sz-1:0]   d_push_q, d_push_d;
  logic                 busy_q, busy_d;
  logic                 err_dest_q, err_dest_d;
  logic [LW-1:0]        last_src_q, last_src_d;

  logic [pckg_sz-1:0]   head;
  logic [7:0]           dest;
  logic [LW-1:0]        grant;

  // First requester strictly after 'last', wrapping; the downward loop leaves the nearest one.
  function automatic logic [LW-1:0] next_grant(input logic [LW-1:0] last,
                                               input logic [drvrs-1:0] req);
    logic [LW-1:0] g;
    int            idx;
    g = last;
    for (int k = drvrs; k >= 1; k--) begin
      idx = (int'(last) + k) % drvrs;
      if (req[idx[LW-1:0]]) g = idx[LW-1:0];
    end
    return g;
  endfunction

  always_comb begin
    head = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (last_src_q == LW'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
    end
    dest  = head[pckg_sz-1 -: 8];
    grant = next_grant(last_src_q, pndng);

    state_d    = state_q;
    pop_d      = '0;
    push_d     = '0;
    err_dest_d = 1'b0;
    busy_d     = 1'b0;
    d_push_d   = d_push_q;
    last_src_d = last_src_q;

    case (state_q)
      IDLE, ROUTE: begin
        state_d = IDLE;
        if (|pndng) begin
          state_d     = GRANT;
          pop_d[grant] = 1'b1;
          last_src_d  = grant;
          busy_d      = 1'b1;
        end
      end
      GRANT: begin
        // Routing is decided from the popped head so push lands in ROUTE with registered outputs.
        state_d  = ROUTE;
        busy_d   = 1'b1;
        d_push_d = head;
        if (dest == broadcast) begin
          push_d = '1;
`ifndef BUS_SCHED_SELF_SEND_EN
          push_d[last_src_q] = 1'b0;
`endif
        end else if (dest < 8'(drvrs)) begin
          if (dest == 8'(last_src_q)) begin
`ifdef BUS_SCHED_SELF_SEND_EN
            push_d[last_src_q] = 1'b1;
`else
            err_dest_d = 1'b1;
`endif
          end else begin
            push_d[dest[LW-1:0]] = 1'b1;
          end
        end else begin
          err_dest_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      busy_q     <= 1'b0;
      err_dest_q <= 1'b0;
      last_src_q <= LW'(drvrs - 1);
    end else begin
      state_q    <= state_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      d_push_q   <= d_push_d;
      busy_q     <= busy_d;
      err_dest_q <= err_dest_d;
      last_src_q <= last_src_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign busy     = busy_q;
  assign err_dest = err_dest_q;
  assign last_src = last_src_q;
endmodule
